// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - streaming 3x3 neighbourhood generator for the Sobel stage
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   pix_in, pix_valid, sof   raster-order 8-bit pixel stream, sof marks pixel (0,0)
//   a0..a7, ctr              neighbours of / centre pixel of the emitted window
//   win_x, win_y             centre coordinates of the emitted window
//   win_valid, win_last      one-cycle window strobe, final-window-of-frame marker
module sobel_window_gen #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    input  logic       sof,
    output logic [7:0] a0,
    output logic [7:0] a1,
    output logic [7:0] a2,
    output logic [7:0] a3,
    output logic [7:0] a4,
    output logic [7:0] a5,
    output logic [7:0] a6,
    output logic [7:0] a7,
    output logic [7:0] ctr,
    output logic [9:0] win_x,
    output logic [9:0] win_y,
    output logic       win_valid,
    output logic       win_last
);

    localparam int         AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
    localparam logic [9:0] Y_LAST = 10'(IMG_H - 1);

    logic [9:0] x, y;
    logic       armed;
    logic       accept;
    logic [9:0] cur_x, cur_y;

    // sof always wins: the pixel carrying it is (0,0) whatever the counters say
    assign accept = pix_valid && (sof || armed);
    assign cur_x  = sof ? 10'd0 : x;
    assign cur_y  = sof ? 10'd0 : y;

    // line buffers: lb1 holds row y-1, lb2 holds row y-2, both indexed by column
    logic [7:0] lb1 [IMG_W];
    logic [7:0] lb2 [IMG_W];
    logic [7:0] rd1, rd2;

    // stage 1: accepted pixel plus the column read from the line buffers
    logic       s1_valid;
    logic [7:0] s1_pix;
    logic [9:0] s1_x, s1_y;

    // 3x3 window, column 0 oldest (x-2), column 2 newest (x)
    logic [7:0] wt [3];
    logic [7:0] wm [3];
    logic [7:0] wb [3];

    // stage 2: window decision for the column just shifted in
    logic       s2_valid, s2_last;
    logic [9:0] s2_x, s2_y;

    // lb2 is refilled one cycle late with the row lb1 just gave up, so each
    // column moves down a row without needing a second read port on lb1
    always_ff @(posedge clk) begin
        if (accept) begin
            rd1                <= lb1[cur_x[AW-1:0]];
            rd2                <= lb2[cur_x[AW-1:0]];
            lb1[cur_x[AW-1:0]] <= pix_in;
        end
        if (s1_valid) begin
            lb2[s1_x[AW-1:0]] <= rd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x         <= '0;
            y         <= '0;
            armed     <= 1'b0;
            s1_valid  <= 1'b0;
            s1_pix    <= '0;
            s1_x      <= '0;
            s1_y      <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_x      <= '0;
            s2_y      <= '0;
            for (int i = 0; i < 3; i++) begin
                wt[i] <= '0;
                wm[i] <= '0;
                wb[i] <= '0;
            end
            a0        <= '0;
            a1        <= '0;
            a2        <= '0;
            a3        <= '0;
            a4        <= '0;
            a5        <= '0;
            a6        <= '0;
            a7        <= '0;
            ctr       <= '0;
            win_x     <= '0;
            win_y     <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            // position tracking
            s1_valid <= accept;
            if (accept) begin
                s1_pix <= pix_in;
                s1_x   <= cur_x;
                s1_y   <= cur_y;
                armed  <= 1'b1;
                if (cur_x == X_LAST) begin
                    x <= '0;
                    if (cur_y == Y_LAST) begin
                        y     <= '0;
                        armed <= 1'b0;
                    end else begin
                        y <= cur_y + 10'd1;
                    end
                end else begin
                    x <= cur_x + 10'd1;
                    y <= cur_y;
                end
            end

            // window shift; columns 0/1 of a row never emit, so stale columns
            // from the previous row are never seen at the output
            s2_valid <= s1_valid && (s1_x >= 10'd2) && (s1_y >= 10'd2);
            s2_last  <= s1_valid && (s1_x == X_LAST) && (s1_y == Y_LAST);
            if (s1_valid) begin
                s2_x  <= s1_x - 10'd1;
                s2_y  <= s1_y - 10'd1;
                wt[0] <= wt[1];
                wt[1] <= wt[2];
                wt[2] <= rd2;
                wm[0] <= wm[1];
                wm[1] <= wm[2];
                wm[2] <= rd1;
                wb[0] <= wb[1];
                wb[1] <= wb[2];
                wb[2] <= s1_pix;
            end

            // registered outputs, held while no window is presented
            win_valid <= s2_valid;
            win_last  <= s2_last;
            if (s2_valid) begin
                a0    <= wt[0];
                a1    <= wt[1];
                a2    <= wt[2];
                a3    <= wm[2];
                a4    <= wb[2];
                a5    <= wb[1];
                a6    <= wb[0];
                a7    <= wm[0];
                ctr   <= wm[1];
                win_x <= s2_x;
                win_y <= s2_y;
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - self-checking bench for sobel_window_gen
module tb_sobel_window_gen;

    localparam int WA = 5;
    localparam int HA = 4;
    localparam int WB = 320;
    localparam int HB = 240;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] pa, pb;
    logic       va, sa, vb, sb;
    logic [7:0] a_a0, a_a1, a_a2, a_a3, a_a4, a_a5, a_a6, a_a7, a_ctr;
    logic [9:0] a_win_x, a_win_y;
    logic       a_win_valid, a_win_last;
    logic [7:0] b_a0, b_a1, b_a2, b_a3, b_a4, b_a5, b_a6, b_a7, b_ctr;
    logic [9:0] b_win_x, b_win_y;
    logic       b_win_valid, b_win_last;

    sobel_window_gen #(.IMG_W(WA), .IMG_H(HA)) dut_a (
        .clk(clk), .rst(rst), .pix_in(pa), .pix_valid(va), .sof(sa),
        .a0(a_a0), .a1(a_a1), .a2(a_a2), .a3(a_a3), .a4(a_a4), .a5(a_a5),
        .a6(a_a6), .a7(a_a7), .ctr(a_ctr), .win_x(a_win_x), .win_y(a_win_y),
        .win_valid(a_win_valid), .win_last(a_win_last)
    );

    sobel_window_gen #(.IMG_W(WB), .IMG_H(HB)) dut_b (
        .clk(clk), .rst(rst), .pix_in(pb), .pix_valid(vb), .sof(sb),
        .a0(b_a0), .a1(b_a1), .a2(b_a2), .a3(b_a3), .a4(b_a4), .a5(b_a5),
        .a6(b_a6), .a7(b_a7), .ctr(b_ctr), .win_x(b_win_x), .win_y(b_win_y),
        .win_valid(b_win_valid), .win_last(b_win_last)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, ctr;
        logic       last;
    } win_t;

    typedef struct {
        win_t w;
        int   due;
    } exp_t;

    int         n_vec = 0;
    int         n_bad = 0;
    int         ncnt  = 0;
    bit         mon_on = 1'b0;
    exp_t       exp_q[$];
    win_t       got_q[$];
    win_t       held;
    win_t       tbl[6];
    logic [7:0] img[HA][WA];
    int         mx, my;
    bit         marmed;

    int         cnt_b = 0, last_cnt_b = 0, bad_b = 0;
    logic [9:0] last_x_b = '0, last_y_b = '0;
    logic [7:0] spot_b = '0;

    task automatic chk(string nm, logic [127:0] got, logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    function automatic win_t act_a();
        return {a_win_x, a_win_y, a_a0, a_a1, a_a2, a_a3, a_a4, a_a5, a_a6, a_a7, a_ctr, a_win_last};
    endfunction

    // monitor for the small instance: compares every strobe with the model queue
    always @(negedge clk) begin
        win_t w, hc;
        exp_t e;
        ncnt++;
        if (mon_on) begin
            w = act_a();
            if (a_win_valid) begin
                got_q.push_back(w);
                if (exp_q.size() == 0) begin
                    chk("unexpected_window", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("window", w, e.w);
                    chk("latency", ncnt, e.due);
                end
                held = w;
            end else begin
                hc      = held;
                hc.last = 1'b0;
                chk("hold", w, hc);
                while (exp_q.size() > 0 && exp_q[0].due < ncnt) begin
                    chk("missing_window", 0, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // monitor for the full-size instance: ramp frame, pixel = (x+y) mod 256
    always @(negedge clk) begin
        int x, y;
        if (mon_on && b_win_valid) begin
            cnt_b++;
            x = int'(b_win_x);
            y = int'(b_win_y);
            if (b_a0 !== 8'(x + y - 2) || b_a1 !== 8'(x + y - 1) || b_a2 !== 8'(x + y) ||
                b_a3 !== 8'(x + y + 1) || b_a4 !== 8'(x + y + 2) || b_a5 !== 8'(x + y + 1) ||
                b_a6 !== 8'(x + y) || b_a7 !== 8'(x + y - 1) || b_ctr !== 8'(x + y))
                bad_b++;
            if (b_win_last) begin
                last_cnt_b++;
                last_x_b = b_win_x;
                last_y_b = b_win_y;
            end
            if (x == 100 && y == 50) spot_b = b_ctr;
        end
    end

    // drive one cycle of the small instance and advance the reference model
    task automatic send(logic [7:0] p, bit v, bit s);
        int cx, cy;
        @(negedge clk);
        #1;
        pa = p;
        va = v;
        sa = s;
        if (v && (s || marmed)) begin
            if (s) begin
                mx     = 0;
                my     = 0;
                marmed = 1'b1;
            end
            img[my][mx] = p;
            if (mx >= 2 && my >= 2) begin
                exp_t e;
                cx    = mx - 1;
                cy    = my - 1;
                e.w   = {10'(cx), 10'(cy),
                         img[cy-1][cx-1], img[cy-1][cx], img[cy-1][cx+1],
                         img[cy][cx+1], img[cy+1][cx+1], img[cy+1][cx],
                         img[cy+1][cx-1], img[cy][cx-1], img[cy][cx],
                         (mx == WA - 1 && my == HA - 1)};
                e.due = ncnt + 3;
                exp_q.push_back(e);
            end
            if (mx == WA - 1) begin
                mx = 0;
                if (my == HA - 1) begin
                    my     = 0;
                    marmed = 1'b0;
                end else begin
                    my++;
                end
            end else begin
                mx++;
            end
        end
    endtask

    task automatic idle(int n);
        repeat (n) send(8'd0, 1'b0, 1'b0);
    endtask

    task automatic frame_a(bit gaps, bit rnd);
        logic [7:0] p;
        for (int y = 0; y < HA; y++) begin
            for (int x = 0; x < WA; x++) begin
                if (gaps) idle($urandom_range(0, 5));
                p = rnd ? 8'($urandom) : 8'(10 * y + x);
                send(p, 1'b1, (x == 0 && y == 0));
            end
        end
    endtask

    task automatic drain();
        idle(5);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic tbl_check();
        chk("tbl_count", got_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < got_q.size()) chk($sformatf("tbl_win%0d", i), got_q[i], tbl[i]);
        end
        got_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst    = 1'b0;
        va     = 1'b0;
        sa     = 1'b0;
        exp_q.delete();
        held   = '0;
        mx     = 0;
        my     = 0;
        marmed = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_outputs", act_a(), '0);
        chk("reset_valid", a_win_valid, 0);
        rst = 1'b1;
    endtask

    initial begin
        tbl[0] = {10'd1, 10'd1, 8'd0,  8'd1,  8'd2,  8'd12, 8'd22, 8'd21, 8'd20, 8'd10, 8'd11, 1'b0};
        tbl[1] = {10'd2, 10'd1, 8'd1,  8'd2,  8'd3,  8'd13, 8'd23, 8'd22, 8'd21, 8'd11, 8'd12, 1'b0};
        tbl[2] = {10'd3, 10'd1, 8'd2,  8'd3,  8'd4,  8'd14, 8'd24, 8'd23, 8'd22, 8'd12, 8'd13, 1'b0};
        tbl[3] = {10'd1, 10'd2, 8'd10, 8'd11, 8'd12, 8'd22, 8'd32, 8'd31, 8'd30, 8'd20, 8'd21, 1'b0};
        tbl[4] = {10'd2, 10'd2, 8'd11, 8'd12, 8'd13, 8'd23, 8'd33, 8'd32, 8'd31, 8'd21, 8'd22, 1'b0};
        tbl[5] = {10'd3, 10'd2, 8'd12, 8'd13, 8'd14, 8'd24, 8'd34, 8'd33, 8'd32, 8'd22, 8'd23, 1'b1};

        rst    = 1'b0;
        pa     = '0; va = 1'b0; sa = 1'b0;
        pb     = '0; vb = 1'b0; sb = 1'b0;
        held   = '0;
        mx     = 0; my = 0; marmed = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state_a", {act_a(), a_win_valid}, '0);
        chk("reset_state_b", {b_win_x, b_win_y, b_ctr, b_a0, b_a7, b_win_valid, b_win_last}, '0);
        mon_on = 1'b1;
        rst    = 1'b1;

        // continuous 5x4 ramp frame
        frame_a(1'b0, 1'b0);
        drain();
        tbl_check();

        // same frame with random gaps
        frame_a(1'b1, 1'b0);
        drain();
        tbl_check();

        // random pixel values with gaps
        frame_a(1'b1, 1'b1);
        drain();
        got_q.delete();

        // pixels before the first sof are dropped, as are pixels after frame end
        do_reset();
        for (int i = 0; i < 5; i++) send(8'(200 + i), 1'b1, 1'b0);
        frame_a(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) send(8'(150 + i), 1'b1, 1'b0);
        drain();
        tbl_check();
        frame_a(1'b0, 1'b0);
        drain();
        tbl_check();

        // sof after 7 pixels aborts the frame
        for (int i = 0; i < 7; i++) send(8'(90 + i), 1'b1, (i == 0));
        frame_a(1'b0, 1'b0);
        drain();
        tbl_check();

        // reset right after the first window's enabling pixel (2,2)
        for (int i = 0; i < 13; i++) send(8'(10 * (i / WA) + (i % WA)), 1'b1, (i == 0));
        do_reset();
        idle(4);
        frame_a(1'b0, 1'b0);
        drain();
        tbl_check();

        // default-size ramp frame on the second instance
        for (int i = 0; i < WB * HB; i++) begin
            @(negedge clk);
            #1;
            pb = 8'((i % WB) + (i / WB));
            vb = 1'b1;
            sb = (i == 0);
        end
        @(negedge clk);
        #1;
        vb = 1'b0;
        sb = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("big_window_count", cnt_b, (WB - 2) * (HB - 2));
        chk("big_last_count", last_cnt_b, 1);
        chk("big_last_pos", {last_x_b, last_y_b}, {10'd318, 10'd238});
        chk("big_spot_ctr", spot_b, 8'd150);
        chk("big_ramp_values", bad_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 neighbourhood generator that feeds the Sobel gradient stage. It accepts a raster-order 8-bit grayscale pixel stream and buffers the two previous image rows in on-chip line buffers. For each interior pixel it presents the eight neighbours in the labeling the Sobel stage expects, along with the centre pixel, its coordinates and a valid strobe. It sits between the camera/frame-buffer read path and the Sobel operator.

## Interface
- IMG_W, 320, active pixels per line (3..1024)
- IMG_H, 240, lines per frame (3..1024)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset (sampled on rising edge of clk; 0 = reset)
- pix_in  in  8  input pixel
- pix_valid  in  1  pix_in valid this cycle; no backpressure, gaps of any length allowed
- sof  in  1  start of frame; meaningful only when pix_valid=1; marks pixel (0,0)
- a0, a1, a2  out  8  neighbours (x-1,y-1), (x,y-1), (x+1,y-1)
- a7, a3  out  8  neighbours (x-1,y), (x+1,y)
- a6, a5, a4  out  8  neighbours (x-1,y+1), (x,y+1), (x+1,y+1)
- ctr  out  8  centre pixel (x,y)
- win_x, win_y  out  10  centre coordinates
- win_valid  out  1  one-cycle strobe; window outputs valid
- win_last  out  1  with win_valid, marks the final window of the frame, centred at (IMG_W-2, IMG_H-2)

## Operation
- Position counters x (0..IMG_W-1) and y (0..IMG_H-1) advance only on accepted pixels. x wraps to 0 with y+1 at IMG_W-1.
- Accept rule: pix_valid=1 and (sof=1 or armed). sof=1 forces the pixel to (0,0) and sets armed. The pixel at (IMG_W-1, IMG_H-1) clears armed.
- Not armed (after reset, or after frame end): pixels with sof=0 are dropped, with no state change and no window.
- sof mid-frame: the current frame is abandoned. No further windows come from it; the new frame restarts at (0,0).
- Line buffers: two IMG_W x 8 memories (BRAM-inferable, synchronous read) hold rows y-1 and y-2, indexed by x. Contents are not cleared on reset or sof; rows 0/1 are overwritten before any use.
- A 3-column shift window (3 rows x 3 cols) shifts on each accepted pixel.
- Window emission: accepting pixel (x,y) with x>=2 and y>=2 produces the window centred at (x-1,y-1). Only interior centres are emitted: 1..IMG_W-2 by 1..IMG_H-2, giving exactly (IMG_W-2)(IMG_H-2) windows per complete frame.
- No window spans a line wrap: columns x=0 and x=1 of each row never emit.
- Outputs a*/ctr/win_x/win_y are registered and hold their last value while win_valid=0.
- Pixel values pass through unmodified. No arithmetic is applied to the data path.

## Timing
- Latency: win_valid asserts exactly 2 clk cycles after the rising edge that accepts the enabling pixel (x+1,y+1). The latency is fixed regardless of pix_valid gaps.
- Throughput: one window per clk when pix_valid is held high.
- win_valid and win_last are single-cycle strobes per window. Back-to-back strobes are allowed.
- Reset (rst=0 at an edge) forces the following values on the next cycle:
  - win_valid=0, win_last=0
  - a0..a7=0, ctr=0, win_x=0, win_y=0
  - x=0, y=0, armed=0
  - in-flight pipeline entries discarded
- Reset mid-frame behaves like reset: no window from the interrupted frame is ever emitted.
- sof with pix_valid=1 in the same cycle as the last pixel of the previous frame cannot occur; sof takes precedence: the pixel is (0,0).
- Windows already in the 2-stage output pipeline when sof arrives are still delivered. They belong to the old frame and their coordinates are old-frame values.

## Test plan
- 5x4 frame (IMG_W=5, IMG_H=4), pixel = 10*y+x, pix_valid continuous:
  - exactly 6 windows, in order (1,1),(2,1),(3,1),(1,2),(2,2),(3,2)
  - first window: a0=0, a1=1, a2=2, a3=12, a4=22, a5=21, a6=20, a7=10, ctr=11, 2 cycles after pixel (2,2) accepted
  - win_last only with (3,2)
- Same frame with pseudo-random pix_valid gaps (0-5 cycles): identical window sequence and values; each win_valid exactly 2 cycles after its enabling pixel.
- Pixels before the first sof after reset, and 10 extra pixels after frame end: no win_valid, and the counters are unaffected. The next sof frame is correct.
- sof asserted after 7 pixels of a 5x4 frame: no windows from the aborted frame. The following full frame yields the 6 correct windows.
- rst=0 for one cycle mid-frame:
  - next cycle all outputs are 0 and win_valid=0
  - any window pending in the pipeline is suppressed
  - the next frame is correct
- Default 320x240 ramp frame (pixel = (x+y) mod 256): exactly 75684 windows and one win_last at (318,238). A spot-check of ctr at (100,50) gives 150.
